// File: rtl/xm_pkg.sv
// Shared definitions for the 16-bit multi-cycle core: widths, register-file
// indices, byte-lane encoding and the fetch sequencer state type.
package xm_pkg;
    localparam int REG_WIDTH = 16;
    localparam int HALF_WORD = REG_WIDTH / 2;
    localparam int PC_ADDR   = 7;

    // Byte-lane indices into a 2-bit write enable: [BYTE] = low byte, [WORD] = high byte
    localparam int WORD = 0;
    localparam int BYTE = 1;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DONE,
        FAULT
    } fetch_state_t;
endpackage

// File: rtl/fetch_unit_m_if.sv
// Instruction memory read bus between the fetch unit (master) and memory (slave).
interface fetch_unit_m_if #(
    parameter int W = 16
);
    logic [W-1:0] mem_addr;
    logic         mem_rd_req;
    logic         mem_ack;
    logic [W-1:0] mem_rdata;

    modport master (output mem_addr, mem_rd_req, input mem_ack, mem_rdata);
    modport slave  (input mem_addr, mem_rd_req, output mem_ack, mem_rdata);
endinterface

// File: rtl/fetch_unit_m_pc_reg.sv
// Architectural PC register: byte-lane write, relative branch, post-increment
// and the priority mux between them. pc_d_o exposes the next-cycle PC.
module pc_reg_m
    import xm_pkg::*;
#(
    parameter int             W        = 16,
    parameter logic [W-1:0]   RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    input  logic         wr_allow_i,
    input  logic         br_allow_i,
    input  logic [1:0]   wr_en_i,
    input  logic [W-1:0] wr_data_i,
    input  logic         br_en_i,
    input  logic [W-1:0] br_off_i,
    output logic [W-1:0] pc_o,
    output logic [W-1:0] pc_d_o
);
    localparam int HALF = W / 2;

    logic [W-1:0] pc_q, pc_d, wr_val;

    always_comb begin
        wr_val = pc_q;
        if (wr_en_i[BYTE]) wr_val[HALF-1:0] = wr_data_i[HALF-1:0];
        if (wr_en_i[WORD]) wr_val[W-1:HALF] = wr_data_i[W-1:HALF];

        // Increment only happens in FETCH, where writes and branches are blocked anyway
        pc_d = pc_q;
        if (inc_i)
            pc_d = pc_q + W'(2);
        else if (wr_allow_i && (wr_en_i != 2'b00))
            pc_d = wr_val;
        else if (br_allow_i && br_en_i)
            pc_d = pc_q + (br_off_i << 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc_q <= RESET_PC;
        else     pc_q <= pc_d;
    end

    assign pc_o   = pc_q;
    assign pc_d_o = pc_d;
endmodule

// File: rtl/fetch_unit_m.sv
// PC owner and instruction fetch sequencer. Define FETCH_TIMEOUT_EN to fault
// a fetch that waits TIMEOUT_CYCLES without a memory ack.
module fetch_unit_m
    import xm_pkg::*;
#(
    parameter int                     REG_WIDTH      = 16,
    parameter logic [REG_WIDTH-1:0]   RESET_PC       = '0,
    parameter int                     TIMEOUT_CYCLES = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fetch_start_i,
    input  logic                 branch_en_i,
    input  logic [REG_WIDTH-1:0] branch_offset_i,
    input  logic [1:0]           PC_wr_en_i,
    input  logic [REG_WIDTH-1:0] PC_wr_data_i,
    output logic [REG_WIDTH-1:0] pc_o,
    output logic [REG_WIDTH-1:0] ir_o,
    output logic                 ir_valid_o,
    output logic                 busy_o,
    output logic                 fault_o,
    fetch_unit_m_if.master       bus
);
    fetch_state_t         state_q, state_d;
    logic [REG_WIDTH-1:0] ir_q, ir_d;
    logic [REG_WIDTH-1:0] pc, pc_nxt;
    logic                 take_ack, wr_allow, br_allow, timed_out;

    assign take_ack = (state_q == FETCH) && bus.mem_ack;
    assign wr_allow = (state_q == IDLE) || (state_q == DONE);
    assign br_allow = (state_q == IDLE);

    pc_reg_m #(
        .W        (REG_WIDTH),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk        (clk),
        .rst        (rst),
        .inc_i      (take_ack),
        .wr_allow_i (wr_allow),
        .br_allow_i (br_allow),
        .wr_en_i    (PC_wr_en_i),
        .wr_data_i  (PC_wr_data_i),
        .br_en_i    (branch_en_i),
        .br_off_i   (branch_offset_i),
        .pc_o       (pc),
        .pc_d_o     (pc_nxt)
    );

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    // Counts FETCH cycles without ack; held at zero outside FETCH so entry clears it
    always_comb begin
        wait_cnt_d = '0;
        if (state_q == FETCH && !bus.mem_ack) wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wait_cnt_q <= '0;
        else     wait_cnt_q <= wait_cnt_d;
    end

    assign timed_out = (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timed_out      = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            // Alignment is judged on the PC the fetch will actually use
            IDLE:  if (fetch_start_i) state_d = pc_nxt[0] ? FAULT : FETCH;
            FETCH: begin
                if (bus.mem_ack) begin
                    ir_d    = bus.mem_rdata;
                    state_d = DONE;
                end else if (timed_out) begin
                    state_d = FAULT;
                end
            end
            DONE:    state_d = IDLE;
            FAULT:   state_d = FAULT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    assign pc_o           = pc;
    assign ir_o           = ir_q;
    assign ir_valid_o     = (state_q == DONE);
    assign busy_o         = (state_q != IDLE);
    assign fault_o        = (state_q == FAULT);
    assign bus.mem_addr   = pc;
    assign bus.mem_rd_req = (state_q == FETCH);
endmodule

// File: tb/tb_fetch_unit_m.sv
// Directed bench for fetch_unit_m with a cycle-level reference model and literal spot checks.
module tb_fetch_unit_m;
    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_start = 1'b0;
    logic        br_en = 1'b0;
    logic [15:0] br_off = '0;
    logic [1:0]  wr_en = '0;
    logic [15:0] wr_data = '0;
    logic [15:0] pc, ir;
    logic        ir_valid, busy, fault;

    always #5 clk = ~clk;

    fetch_unit_m_if #(.W(16)) bus ();

    fetch_unit_m #(
        .REG_WIDTH      (16),
        .RESET_PC       (16'h0000),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .fetch_start_i   (fetch_start),
        .branch_en_i     (br_en),
        .branch_offset_i (br_off),
        .PC_wr_en_i      (wr_en),
        .PC_wr_data_i    (wr_data),
        .pc_o            (pc),
        .ir_o            (ir),
        .ir_valid_o      (ir_valid),
        .busy_o          (busy),
        .fault_o         (fault),
        .bus             (bus)
    );

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: a fetch is either outstanding, just completed, or the unit is dead.
    int m_pc, m_ir, m_cnt;
    bit m_wait, m_pulse, m_dead, m_idle;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc = 0; m_ir = 0; m_cnt = 0;
            m_wait = 0; m_pulse = 0; m_dead = 0;
        end else if (m_dead) begin
            m_dead = 1;
        end else if (m_wait) begin
            if (bus.mem_ack) begin
                m_ir    = int'(bus.mem_rdata);
                m_pc    = (m_pc + 2) % 65536;
                m_wait  = 0;
                m_pulse = 1;
            end else begin
                m_cnt++;
`ifdef FETCH_TIMEOUT_EN
                if (m_cnt == TO) begin m_wait = 0; m_dead = 1; end
`endif
            end
        end else begin
            m_idle = !m_pulse;
            if (wr_en != 2'b00) begin
                if (wr_en[1]) m_pc = (m_pc / 256) * 256 + int'(wr_data) % 256;
                if (wr_en[0]) m_pc = (int'(wr_data) / 256) * 256 + m_pc % 256;
            end else if (m_idle && br_en) begin
                m_pc = (m_pc + 2 * int'(br_off)) % 65536;
            end
            if (m_idle && fetch_start) begin
                if (m_pc % 2 == 1) m_dead = 1;
                else begin m_wait = 1; m_cnt = 0; end
            end
            m_pulse = 0;
        end
    end

    always @(negedge clk) begin
        chk("pc", {16'h0, pc}, m_pc);
        chk("mem_addr", {16'h0, bus.mem_addr}, m_pc);
        chk("ir", {16'h0, ir}, m_ir);
        chk("mem_rd_req", {31'h0, bus.mem_rd_req}, {31'h0, m_wait});
        chk("ir_valid", {31'h0, ir_valid}, {31'h0, m_pulse});
        chk("busy", {31'h0, busy}, {31'h0, (m_wait | m_pulse | m_dead)});
        chk("fault", {31'h0, fault}, {31'h0, m_dead});
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic clr();
        fetch_start = 0; br_en = 0; br_off = '0; wr_en = '0; wr_data = '0; bus.mem_ack = 0;
    endtask

    task automatic wr(input logic [1:0] en, input logic [15:0] d);
        wr_en = en; wr_data = d; tick(); clr();
    endtask

    task automatic ack(input logic [15:0] d);
        bus.mem_ack = 1; bus.mem_rdata = d; tick(); clr();
    endtask

    initial begin
        bus.mem_ack = 0; bus.mem_rdata = '0;
        tick(2);
        chk("rst_pc", {16'h0, pc}, 32'h0000);
        chk("rst_req", {31'h0, bus.mem_rd_req}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_fault", {31'h0, fault}, 32'h0);
        chk("rst_ir", {16'h0, ir}, 32'h0000);
        rst = 0; tick();

        // First fetch, ack on the second FETCH cycle
        fetch_start = 1; tick(); clr();
        chk("f1_req", {31'h0, bus.mem_rd_req}, 32'h1);
        chk("f1_addr", {16'h0, bus.mem_addr}, 32'h0000);
        tick();
        ack(16'hA5C3);
        chk("f1_irv", {31'h0, ir_valid}, 32'h1);
        chk("f1_ir", {16'h0, ir}, 32'hA5C3);
        chk("f1_pc", {16'h0, pc}, 32'h0002);
        tick();
        chk("f1_irv_off", {31'h0, ir_valid}, 32'h0);
        bus.mem_ack = 1; bus.mem_rdata = 16'hFFFF; tick(); clr();
        chk("stray_ack_ir", {16'h0, ir}, 32'hA5C3);

        // Full and low-byte PC writes
        wr(2'b11, 16'h1234);
        fetch_start = 1; tick(); clr();
        chk("f2_addr", {16'h0, bus.mem_addr}, 32'h1234);
        ack(16'h1111);
        chk("f2_pc", {16'h0, pc}, 32'h1236);
        tick();
        wr(2'b10, 16'h00FE);
        chk("lowbyte_pc", {16'h0, pc}, 32'h12FE);

        // Branches, and write beating a branch
        wr(2'b11, 16'h0100);
        br_en = 1; br_off = 16'hFFFE; tick(); clr();
        chk("br_neg", {16'h0, pc}, 32'h00FC);
        wr_en = 2'b11; wr_data = 16'h0200; br_en = 1; br_off = 16'h0005; tick(); clr();
        chk("wr_wins", {16'h0, pc}, 32'h0200);

        // Branch with fetch_start: fetch uses the branched PC; updates in FETCH ignored
        br_en = 1; br_off = 16'h0003; fetch_start = 1; tick(); clr();
        chk("brf_addr", {16'h0, bus.mem_addr}, 32'h0206);
        wr_en = 2'b11; wr_data = 16'h5555; br_en = 1; br_off = 16'h0001; fetch_start = 1; tick(); clr();
        chk("fetch_nowr", {16'h0, pc}, 32'h0206);
        ack(16'hBEEF);
        chk("brf_pc", {16'h0, pc}, 32'h0208);
        wr_en = 2'b01; wr_data = 16'hAB00; fetch_start = 1; tick(); clr();
        chk("done_hibyte", {16'h0, pc}, 32'hAB08);
        chk("done_nostart", {31'h0, bus.mem_rd_req}, 32'h0);

        // Wrap-around
        wr(2'b11, 16'hFFFE);
        fetch_start = 1; tick(); clr();
        ack(16'h0F0F);
        chk("wrap_pc", {16'h0, pc}, 32'h0000);
        chk("wrap_fault", {31'h0, fault}, 32'h0);
        tick();

        // Reset mid-fetch
        wr(2'b11, 16'h4444);
        fetch_start = 1; tick(); clr();
        chk("mid_req", {31'h0, bus.mem_rd_req}, 32'h1);
        rst = 1; #1;
        chk("async_req", {31'h0, bus.mem_rd_req}, 32'h0);
        chk("async_pc", {16'h0, pc}, 32'h0000);
        tick(); rst = 0; tick();

        // Long wait without ack
        fetch_start = 1; tick(); clr();
`ifdef FETCH_TIMEOUT_EN
        tick(TO - 1);
        chk("to_before", {31'h0, fault}, 32'h0);
        tick();
        chk("to_fault", {31'h0, fault}, 32'h1);
        chk("to_req", {31'h0, bus.mem_rd_req}, 32'h0);
        chk("to_pc", {16'h0, pc}, 32'h0000);
`else
        tick(100);
        chk("nto_req", {31'h0, bus.mem_rd_req}, 32'h1);
        chk("nto_fault", {31'h0, fault}, 32'h0);
`endif
        rst = 1; tick(); rst = 0; tick();

        // Misaligned fetch is sticky until reset
        wr(2'b11, 16'h0003);
        fetch_start = 1; tick(); clr();
        chk("mis_fault", {31'h0, fault}, 32'h1);
        chk("mis_req", {31'h0, bus.mem_rd_req}, 32'h0);
        repeat (3) begin
            wr_en = 2'b11; wr_data = 16'h0000; br_en = 1; br_off = 16'h0001; fetch_start = 1; tick(); clr();
        end
        chk("mis_pc_held", {16'h0, pc}, 32'h0003);
        chk("mis_sticky", {31'h0, fault}, 32'h1);
        rst = 1; tick(); rst = 0; tick();
        chk("mis_cleared", {31'h0, fault}, 32'h0);

        // Write with fetch_start: alignment judged on written value
        wr(2'b11, 16'h0001);
        wr_en = 2'b11; wr_data = 16'h0010; fetch_start = 1; tick(); clr();
        chk("wrf_addr", {16'h0, bus.mem_addr}, 32'h0010);
        chk("wrf_req", {31'h0, bus.mem_rd_req}, 32'h1);
        ack(16'h7777);
        tick();
        wr_en = 2'b11; wr_data = 16'h0005; fetch_start = 1; tick(); clr();
        chk("wrf_mis", {31'h0, fault}, 32'h1);
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
